// File: rtl/crank_wheel_gen.sv
// N-minus-M crank trigger-wheel generator.
// Emits one revolution of teeth per latched config; missing slots sit at the end.
module crank_wheel_gen #(
    parameter int CNT_W = 16,
    parameter int PER_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] tooth_cnt,
    input  logic [CNT_W-1:0] teeth_missing,
    input  logic [PER_W-1:0] tooth_period,
    output logic             vr_out,
    output logic [CNT_W-1:0] tooth_idx,
    output logic             rev_pulse,
    output logic             running,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state, state_n;
    logic [PER_W-1:0] cnt, cnt_n, sh_per, half;
    logic [CNT_W-1:0] sh_cnt, sh_miss, idx_n, idx_inc, first_miss;
    logic             cfg_ok, slot_end, last_slot, next_miss;
    logic             latch, err_n;

    assign cfg_ok = (tooth_cnt >= CNT_W'(2)) &&
                    (teeth_missing < tooth_cnt) &&
                    (tooth_period >= PER_W'(4));

    assign half       = sh_per >> 1;
    assign slot_end   = (state == LOW) && (cnt == sh_per - PER_W'(1));
    assign last_slot  = (tooth_idx == sh_cnt - CNT_W'(1));
    assign idx_inc    = tooth_idx + CNT_W'(1);
    assign first_miss = sh_cnt - sh_miss;
    assign next_miss  = (idx_inc >= first_miss);

    // Config is only sampled at the start of a revolution
    assign latch = enable && cfg_ok &&
                   ((state == IDLE) || (slot_end && last_slot));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (enable && cfg_ok) state_n = HIGH;
            end
            HIGH: begin
                if (!enable)                       state_n = IDLE;
                else if (cnt == half - PER_W'(1))  state_n = LOW;
            end
            LOW: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (slot_end) begin
                    if (last_slot) state_n = cfg_ok ? HIGH : IDLE;
                    else           state_n = next_miss ? LOW : HIGH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n = cnt + PER_W'(1);
        if (state_n == IDLE || state == IDLE || slot_end) cnt_n = '0;

        idx_n = tooth_idx;
        if (state_n == IDLE || latch) idx_n = '0;
        else if (slot_end)            idx_n = idx_inc;

        err_n = cfg_err;
        if (!enable)                                    err_n = 1'b0;
        else if (state == IDLE || (slot_end && last_slot)) err_n = !cfg_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            tooth_idx <= '0;
            vr_out    <= 1'b0;
            rev_pulse <= 1'b0;
            running   <= 1'b0;
            cfg_err   <= 1'b0;
            sh_cnt    <= '0;
            sh_miss   <= '0;
            sh_per    <= '0;
        end else begin
            cnt       <= cnt_n;
            tooth_idx <= idx_n;
            vr_out    <= (state_n == HIGH);
            rev_pulse <= latch;
            running   <= (state_n != IDLE);
            cfg_err   <= err_n;
            if (latch) begin
                sh_cnt  <= tooth_cnt;
                sh_miss <= teeth_missing;
                sh_per  <= tooth_period;
            end
        end
    end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: vector table, corner sequences and a
// revolution-position reference model driven with random configs.
module tb_crank_wheel_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] tooth_cnt = '0;
    logic [15:0] teeth_missing = '0;
    logic [31:0] tooth_period = '0;
    logic        vr_out, rev_pulse, running, cfg_err;
    logic [15:0] tooth_idx;

    int tests = 0;
    int fails = 0;

    // Reference: position m_t within the current revolution
    bit m_act, m_err;
    int m_n, m_m, m_p, m_t;

    crank_wheel_gen #(.CNT_W(16), .PER_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .tooth_cnt(tooth_cnt), .teeth_missing(teeth_missing),
        .tooth_period(tooth_period), .vr_out(vr_out),
        .tooth_idx(tooth_idx), .rev_pulse(rev_pulse),
        .running(running), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n; int m; int p;
        bit err; int rev_len; int highs;
    } vec_t;

    function automatic bit cfg_valid();
        return tooth_cnt >= 2 && teeth_missing < tooth_cnt && tooth_period >= 4;
    endfunction

    task automatic model_latch();
        m_n = int'(tooth_cnt);
        m_m = int'(teeth_missing);
        m_p = int'(tooth_period);
    endtask

    task automatic model_edge();
        if (!enable) begin
            m_act = 0; m_err = 0; m_t = 0;
        end else if (!m_act) begin
            if (cfg_valid()) begin
                model_latch(); m_act = 1; m_t = 0; m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_t++;
            if (m_t == m_n * m_p) begin
                m_t = 0;
                if (cfg_valid()) begin
                    model_latch(); m_err = 0;
                end else begin
                    m_act = 0; m_err = 1;
                end
            end
        end
    endtask

    task automatic check(string name);
        logic ev, er, eu;
        int   ei;
        ev = 0; ei = 0; er = 0; eu = m_act;
        if (m_act) begin
            ev = (m_t / m_p < m_n - m_m) && (m_t % m_p < m_p / 2);
            ei = m_t / m_p;
            er = (m_t == 0);
        end
        tests++;
        if (vr_out !== ev || int'(tooth_idx) != ei || rev_pulse !== er ||
            running !== eu || cfg_err !== m_err) begin
            fails++;
            $display("FAIL %s t=%0t: got vr=%0b idx=%0d rev=%0b run=%0b err=%0b, want vr=%0b idx=%0d rev=%0b run=%0b err=%0b",
                     name, $time, vr_out, tooth_idx, rev_pulse, running, cfg_err,
                     ev, ei, er, eu, m_err);
        end
    endtask

    task automatic step(string name);
        @(posedge clk);
        model_edge();
        #1;
        check(name);
    endtask

    task automatic expect_int(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic do_reset(string name);
        reset_n = 1'b0;
        #2;
        m_act = 0; m_err = 0; m_t = 0;
        check(name);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_cfg(int n, int m, int p);
        tooth_cnt = 16'(n);
        teeth_missing = 16'(m);
        tooth_period = 32'(p);
    endtask

    task automatic wait_rev(string name, int lim);
        int k = 0;
        while (!rev_pulse && k < lim) begin
            step(name);
            k++;
        end
        expect_int({name, "_timeout"}, int'(rev_pulse), 1);
    endtask

    // Starting on a rev_pulse cycle, measure one revolution
    task automatic measure_rev(string name, output int len, output int hi);
        len = 0; hi = 0;
        do begin
            hi += int'(vr_out);
            step(name);
            len++;
        end while (!rev_pulse && len < 2000);
    endtask

    initial begin
        vec_t tbl[10];
        int len, hi;
        tbl = '{
            '{36, 1, 8, 1'b0, 288, 140},
            '{4,  0, 5, 1'b0, 20,  8},
            '{4,  0, 4, 1'b0, 16,  8},
            '{3,  1, 7, 1'b0, 21,  6},
            '{2,  1, 4, 1'b0, 8,   2},
            '{60, 2, 6, 1'b0, 360, 174},
            '{12, 12, 8, 1'b1, 0,  0},
            '{1,  0, 8, 1'b1, 0,   0},
            '{5,  0, 3, 1'b1, 0,   0},
            '{4,  5, 8, 1'b1, 0,   0}
        };

        do_reset("reset");

        foreach (tbl[i]) begin
            do_reset("tbl_reset");
            set_cfg(tbl[i].n, tbl[i].m, tbl[i].p);
            enable = 1'b1;
            if (tbl[i].err) begin
                repeat (3) step("tbl_err");
                expect_int("tbl_cfg_err", int'(cfg_err), 1);
                expect_int("tbl_err_idle", int'(running | vr_out), 0);
            end else begin
                wait_rev("tbl_start", 4);
                measure_rev("tbl_rev", len, hi);
                expect_int("tbl_rev_len", len, tbl[i].rev_len);
                expect_int("tbl_highs", hi, tbl[i].highs);
            end
            enable = 1'b0;
            step("tbl_stop");
        end

        // Mid-revolution config change takes effect at the next wrap
        do_reset("chg_reset");
        set_cfg(36, 1, 8);
        enable = 1'b1;
        wait_rev("chg_start", 4);
        begin
            int k = 0;
            while (tooth_idx != 10 && k < 200) begin step("chg_run"); k++; end
        end
        expect_int("chg_at_idx10", int'(tooth_idx), 10);
        set_cfg(60, 2, 6);
        step("chg_old");
        wait_rev("chg_wrap", 300);
        measure_rev("chg_new", len, hi);
        expect_int("chg_new_len", len, 360);
        expect_int("chg_new_highs", hi, 174);

        // Invalid config then fixed
        do_reset("err_reset");
        set_cfg(12, 12, 8);
        enable = 1'b1;
        step("err_hold");
        step("err_hold");
        teeth_missing = 16'd1;
        step("err_fix");
        expect_int("err_fix_run_vr", int'(running & vr_out), 1);

        // Disable mid-HIGH, async reset mid-LOW, restart
        enable = 1'b0;
        step("dis_stop");
        set_cfg(36, 1, 8);
        enable = 1'b1;
        wait_rev("dis_start", 4);
        step("dis_high");
        enable = 1'b0;
        step("dis_drop");
        expect_int("dis_vr_idx", int'(vr_out) + int'(tooth_idx), 0);
        enable = 1'b1;
        repeat (7) step("rst_run");
        expect_int("rst_in_low", int'(running & ~vr_out), 1);
        do_reset("rst_async");
        step("rst_restart");
        expect_int("rst_restart_rev", int'(rev_pulse), 1);

        // Random configs and enable toggling
        do_reset("rnd_reset");
        set_cfg(6, 1, 5);
        enable = 1'b1;
        repeat (4000) begin
            if ($urandom_range(0, 59) == 0)
                set_cfg($urandom_range(1, 8), $urandom_range(0, 9),
                        $urandom_range(2, 9));
            if ($urandom_range(0, 149) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
